// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: default operand
// width, controller states and the iteration-counter sizing rule.
package booth_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // The counter must hold the full iteration count, hence w+1.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator, then an arithmetic right shift of {A,Q,q_1}.
module booth_step #(
    parameter int WIDTH = booth_pkg::WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);
    import booth_pkg::*;

    logic [WIDTH:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_next   = {sum[WIDTH], sum[WIDTH:1]};
        q_next   = {sum[0], q[WIDTH-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/integration_booth.sv
// Sequential signed Booth multiplier: captures X/Y on en, runs WIDTH
// iterations through booth_step, then registers the product on Z.
module integration_booth #(
    parameter int WIDTH = booth_pkg::WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic [2*WIDTH-1:0]   Z
);
    import booth_pkg::*;

    localparam int CW = count_width(WIDTH);

    state_t          state;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic             q_1;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] mplier_nx;
    logic             q_1_nx;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a        (acc),
        .q        (mplier),
        .q_1      (q_1),
        .m        (mcand),
        .a_next   (acc_nx),
        .q_next   (mplier_nx),
        .q_1_next (q_1_nx)
    );

    // The accumulator carries one extra bit so negating the most-negative
    // multiplicand cannot overflow; Z is written one edge after the last shift.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            Z      <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            q_1    <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        mcand  <= {X[WIDTH-1], X};
                        mplier <= Y;
                        acc    <= '0;
                        q_1    <= 1'b0;
                        count  <= CW'(WIDTH);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (count != '0) begin
                        acc    <= acc_nx;
                        mplier <= mplier_nx;
                        q_1    <= q_1_nx;
                        count  <= count - CW'(1);
                    end else begin
                        Z     <= {acc[WIDTH-1:0], mplier};
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!en) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integration_booth.sv
// Self-checking bench for integration_booth: directed and random operands
// against a plain signed-multiply reference, with latency and abort checks.
module tb_integration_booth;

    localparam int W = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic [W-1:0]     X = '0;
    logic [W-1:0]     Y = '0;
    logic [2*W-1:0]   Z;

    int compared = 0;
    int mismatched = 0;

    integration_booth #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .X     (X),
        .Y     (Y),
        .Z     (Z)
    );

    always #10 clock = ~clock;

    function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] x, input logic [W-1:0] y);
        longint a;
        longint b;
        a = $signed(x);
        b = $signed(y);
        return a * b;
    endfunction

    task automatic checkOutput(input string tag, input logic [2*W-1:0] expected);
        compared++;
        assert (Z === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: Z=%h expected %h", tag, Z, expected);
        end
    endtask

    // Edge 0 samples en; Z must hold prev through edge 32 and show exp at 33.
    task automatic checkRun(input string tag, input logic [2*W-1:0] expected,
                            input logic [2*W-1:0] prev, input bit scramble);
        @(posedge clock);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k < 33) checkOutput($sformatf("%s_hold%0d", tag, k), prev);
            else        checkOutput($sformatf("%s_edge33", tag), expected);
            if (scramble && k == 5) begin
                X = $urandom;
                Y = $urandom;
            end
            if (scramble && k == 8) en = 1'b0;
        end
        repeat (7) @(negedge clock);
        checkOutput($sformatf("%s_stable", tag), expected);
    endtask

    task automatic applyStimulus(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clock);
        X = x;
        Y = y;
        en = 1'b1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput($sformatf("%s_reset", tag), '0);
        reset = 1'b1;
        checkRun(tag, refProduct(x, y), '0, 1'b0);
    endtask

    task automatic runFromIdle(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [2*W-1:0] prev, input bit scramble);
        @(negedge clock);
        en = 1'b0;
        @(negedge clock);
        X = x;
        Y = y;
        en = 1'b1;
        checkRun(tag, refProduct(x, y), prev, scramble);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [W-1:0]   dx [9];
        logic [W-1:0]   dy [9];
        logic [W-1:0]   rx;
        logic [W-1:0]   ry;
        logic [2*W-1:0] last;

        dx = '{32'd2, 32'd0, 32'd1, 32'd524290, -32'sd2, 32'd2, -32'sd2, -32'sd7, 32'h8000_0000};
        dy = '{32'd4, 32'd67108868, 32'd67108868, 32'd67108868, 32'd4, -32'sd3, -32'sd4, -32'sd4, 32'h8000_0000};

        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("por_reset", '0);

        for (int i = 0; i < 9; i++)
            applyStimulus($sformatf("dir%0d", i), dx[i], dy[i]);
        last = refProduct(dx[8], dy[8]);

        // Back-to-back products from IDLE with operands disturbed mid-run.
        for (int i = 0; i < 8; i++) begin
            rx = $urandom;
            ry = $urandom;
            if (i == 0) rx = 32'h8000_0000;
            if (i == 1) ry = 32'h7FFF_FFFF;
            runFromIdle($sformatf("rnd%0d", i), rx, ry, last, i[0]);
            last = refProduct(rx, ry);
        end

        // Abort mid-run, then restart with en held through release.
        @(negedge clock);
        en = 1'b0;
        @(negedge clock);
        X = $urandom;
        Y = $urandom;
        en = 1'b1;
        repeat (11) @(posedge clock);
        @(negedge clock);
        checkOutput("abort_pre", last);
        reset = 1'b0;
        #1;
        checkOutput("abort_async", '0);
        rx = $urandom;
        ry = $urandom;
        X = rx;
        Y = ry;
        @(negedge clock);
        checkOutput("abort_held", '0);
        reset = 1'b1;
        checkRun("restart", refProduct(rx, ry), '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
